// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: default operand width,
// FSM state encoding and a helper for sizing the bit counter.
package sub_pkg;

  // Default operand width when the parent does not override WIDTH.
  localparam int SUB_WIDTH_DEFAULT = 8;

  // Controller states. IDLE and DONE both accept a new start; RUN ignores it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_e;

  // Counter width. The extra bit lets the counter reach WIDTH on the final
  // RUN edge without wrapping.
  function automatic int sub_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/bit_serial_sub_ctrl_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with a borrow out.
// It is built from two half subtractors and an OR that merges their borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  // First half subtractor: a - b.
  assign hs1_d = a ^ b;
  assign hs1_b = ~a & b;

  // Second half subtractor: (a - b) - bin.
  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  // The two half-stage borrows can never both be set, so an OR merges them.
  assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/bit_serial_sub_ctrl.sv
// Bit-serial subtractor controller. It computes a - b mod 2^WIDTH, one bit
// per clock, LSB first.
// A start in IDLE/DONE loads the operands. WIDTH RUN cycles follow, then a
// one-cycle DONE pulse, and diff/bout update in that same step. diff/bout
// hold their value until the next completion.
module bit_serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = sub_cnt_w(WIDTH);

  sub_state_e       state;
  logic [WIDTH-1:0] sh_a;   // minuend, consumed from bit 0
  logic [WIDTH-1:0] sh_b;   // subtrahend, consumed from bit 0
  logic [WIDTH-1:0] sh_r;   // result, filled from the MSB side
  logic [CW-1:0]    cnt;
  logic             brw;

  logic bit_d;
  logic bit_b;
  logic last_bit;

  // Per-bit arithmetic on the current LSBs and the running borrow.
  full_subtractor u_fs (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .bin  (brw),
    .d    (bit_d),
    .bout (bit_b)
  );

  // The final bit is processed on the edge where the counter reads WIDTH-1.
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Controller FSM, datapath shifters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      sh_r  <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            sh_a  <= a;
            sh_b  <= b;
            cnt   <= '0;
            brw   <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          // start, a and b are ignored here; only the shifters feed the math.
          sh_a <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b <= {1'b0, sh_b[WIDTH-1:1]};
          sh_r <= {bit_d, sh_r[WIDTH-1:1]};
          brw  <= bit_b;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            // Take the last bit straight from the subtractor, because sh_r
            // updates on this same edge.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= {bit_d, sh_r[WIDTH-1:1]};
            bout  <= bit_b;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_sub_ctrl.sv
// Directed and random bench for bit_serial_sub_ctrl (WIDTH=8).
// Expected results come from plain arithmetic on the captured operands.
module tb_bit_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_assert;
  int n_fail;

  // Last completed result, as the reference model sees it.
  logic [W-1:0] exp_diff;
  logic         exp_bout;

  bit_serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The task starts at a negedge. It drives start with operands ia/ib and
  // checks the next WIDTH+1 cycles.
  // hold keeps start high throughout, so a new operation follows at once.
  // disturb pulses start and changes a/b in RUN cycle 3.
  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                    input bit hold, input bit disturb);
    logic [W-1:0] new_d;
    logic         new_b;
    new_d = W'((int'(ia) - int'(ib)) & ((1 << W) - 1));
    new_b = (ia < ib);
    a = ia;
    b = ib;
    start = 1'b1;
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (disturb && cyc == 3) begin
        a = W'($urandom);
        b = W'($urandom);
        start = 1'b1;
      end
      if (disturb && cyc == 4 && !hold) start = 1'b0;
      if (cyc == W + 1) begin
        exp_diff = new_d;
        exp_bout = new_b;
      end
      chk("busy", busy, (cyc <= W));
      chk("done", done, (cyc == W + 1));
      chk("diff", diff, exp_diff);
      chk("bout", bout, exp_bout);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    exp_diff = '0;
    exp_bout = 1'b0;
    rst_n = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;

    // Assert reset and check the reset values without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Directed cases.
    op(8'h05, 8'h03, 1'b0, 1'b0);
    op(8'h03, 8'h05, 1'b0, 1'b0);
    op(8'h00, 8'h01, 1'b0, 1'b0);
    // Held start back to back, with operand changes in the first operation.
    op(8'hFF, 8'hFF, 1'b1, 1'b1);
    op(8'h10, 8'h20, 1'b1, 1'b0);
    op(8'h7F, 8'h80, 1'b0, 1'b0);
    // start pulse and new operands in RUN are ignored.
    op(8'h9A, 8'h3C, 1'b0, 1'b1);
    // DONE goes back to IDLE and stays there while start is low.
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy2", busy, 0);
    chk("idle_diff", diff, exp_diff);

    // Abort with reset in RUN cycle 4.
    a = 8'h55;
    b = 8'h11;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    exp_diff = '0;
    exp_bout = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      chk("abort_nodone", done, 0);
    end
    op(8'h80, 8'h01, 1'b0, 1'b0);

    // Random operations, mixed held and disturbed starts.
    for (int n = 0; n < 40; n++) begin
      op(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)),
         bit'($urandom_range(0, 1)));
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_diff", diff, exp_diff);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
